// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ---- dmem_arb_pkg : shared region map, arbitration modes, region decode -- rev 1.0 ----
package dmem_arb_pkg;

  localparam logic [15:0] RAM_BASE_HI = 16'h1000;
  localparam logic [15:0] ROM_BASE_HI = 16'h0000;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  typedef enum logic [1:0] {
    REG_RAM     = 2'd0,
    REG_ROM     = 2'd1,
    REG_ILLEGAL = 2'd2
  } region_e;

  function automatic region_e decode_region(input logic [15:0] addr_hi);
    if (addr_hi == RAM_BASE_HI) return REG_RAM;
    if (addr_hi == ROM_BASE_HI) return REG_ROM;
    return REG_ILLEGAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ---- dmem_arbiter_if : two request ports plus the data-memory port -- rev 1.0 ----
interface dmem_arbiter_if;

  logic        m0_req,    m1_req;
  logic        m0_we,     m1_we;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic [3:0]  m0_wmask,  m1_wmask;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        m0_err,    m1_err;

  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
    input  m0_wdata, m1_wdata, m0_wmask, m1_wmask,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    output mem_write_enable, mem_address, mem_write_data, mem_write_mask,
    input  mem_read_data
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
    output m0_wdata, m1_wdata, m0_wmask, m1_wmask,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    input  mem_write_enable, mem_address, mem_write_data, mem_write_mask,
    output mem_read_data
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ---- dmem_arb_pick : one-hot grant decision for two masters -- rev 1.0 ----
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       fixed_mode,
  input  master_e    last_grant,
  input  logic       starved,
  output logic [1:0] gnt
);

  logic m1_wins_tie;

  always_comb begin
    m1_wins_tie = 1'b0;
    gnt         = {m1_req, m0_req};
    if (m0_req && m1_req) begin
      // Fixed mode only yields to M1 once it has waited long enough
      m1_wins_tie = fixed_mode ? starved : (last_grant == MST_M0);
      gnt         = m1_wins_tie ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---- dmem_arbiter : two-master data-memory arbiter, 1-cycle registered responses -- rev 1.0 ----
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam logic       FIXED_MODE = (ARB_MODE == ARB_FIXED);
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0]  gnt;
  master_e     last_grant;
  logic [3:0]  wait_cnt;
  logic        starved;
  logic        any_gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_mask;
  region_e     region;
  logic        access_err;
  logic [31:0] resp_data;
  logic [1:0]  rvalid_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  assign starved = (wait_cnt >= WAIT_LIMIT);

  dmem_arb_pick u_pick (
    .m0_req     (bus.m0_req & ~reset),
    .m1_req     (bus.m1_req & ~reset),
    .fixed_mode (FIXED_MODE),
    .last_grant (last_grant),
    .starved    (starved),
    .gnt        (gnt)
  );

  always_comb begin
    sel_we    = bus.m0_we;
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    sel_mask  = bus.m0_wmask;
    if (gnt[1]) begin
      sel_we    = bus.m1_we;
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
      sel_mask  = bus.m1_wmask;
    end
  end

  assign any_gnt    = |gnt;
  assign region     = decode_region(sel_addr[31:16]);
  assign access_err = (region == REG_ILLEGAL) || ((region == REG_ROM) && sel_we);
  assign resp_data  = (sel_we || access_err) ? 32'h0 : bus.mem_read_data;

  assign bus.m0_gnt           = gnt[0];
  assign bus.m1_gnt           = gnt[1];
  assign bus.mem_write_enable = any_gnt && sel_we && (region == REG_RAM);
  assign bus.mem_address      = any_gnt ? sel_addr  : 32'h0;
  assign bus.mem_write_data   = any_gnt ? sel_wdata : 32'h0;
  assign bus.mem_write_mask   = any_gnt ? sel_mask  : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
      last_grant <= MST_M1;
      wait_cnt   <= 4'h0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & {2{access_err}};
      if (gnt[0]) rdata0_q <= resp_data;
      if (gnt[1]) rdata1_q <= resp_data;
      if (gnt[0])      last_grant <= MST_M0;
      else if (gnt[1]) last_grant <= MST_M1;
      if (!bus.m1_req || gnt[1])  wait_cnt <= 4'h0;
      else if (wait_cnt != 4'hF)  wait_cnt <= wait_cnt + 4'h1;
    end
  end

  // Masking with reset drops a response that was registered just before reset rose
  assign bus.m0_rvalid = rvalid_q[0] & ~reset;
  assign bus.m1_rvalid = rvalid_q[1] & ~reset;
  assign bus.m0_err    = err_q[0] & ~reset;
  assign bus.m1_err    = err_q[1] & ~reset;
  assign bus.m0_rdata  = reset ? 32'h0 : rdata0_q;
  assign bus.m1_rdata  = reset ? 32'h0 : rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---- tb_dmem_arbiter : scoreboard bench, round-robin DUT (a) and fixed-priority DUT (b) -- rev 1.0 ----
module tb_dmem_arbiter;

  typedef struct packed {
    logic        mst;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] mema [0:255];

  always #5 clk = ~clk;

  dmem_arbiter_if ifa ();
  dmem_arbiter_if ifb ();

  dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Data memory model behind DUT a; DUT b reads an address-derived pattern
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mema[i] <= 32'hCAFE0000 + 32'(i);
    end else if (ifa.mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (ifa.mem_write_mask[b])
          mema[ifa.mem_address[9:2]][8*b +: 8] <= ifa.mem_write_data[8*b +: 8];
    end
  end
  assign ifa.mem_read_data = mema[ifa.mem_address[9:2]];
  assign ifb.mem_read_data = {16'hB000, ifb.mem_address[15:0]};

  function automatic exp_t mk(input logic mst, input logic err, input logic [31:0] rdata);
    mk.mst = mst; mk.err = err; mk.rdata = rdata;
  endfunction

  always @(posedge clk) begin : mon_a
    exp_t e;
    logic gerr;
    logic [31:0] grd;
    #3;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      gerr = e.mst ? ifa.m1_err : ifa.m0_err;
      grd  = e.mst ? ifa.m1_rdata : ifa.m0_rdata;
      tests_run++;
      if ({ifa.m1_rvalid, ifa.m0_rvalid} !== (e.mst ? 2'b10 : 2'b01) || gerr !== e.err || grd !== e.rdata) begin
        tests_failed++;
        $display("FAIL resp_a t=%0t: rvalid=%b err=%b rdata=%h, expected master=%0d err=%b rdata=%h",
                 $time, {ifa.m1_rvalid, ifa.m0_rvalid}, gerr, grd, e.mst, e.err, e.rdata);
      end
    end else if (ifa.m0_rvalid || ifa.m1_rvalid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL resp_a t=%0t: unexpected rvalid=%b, expected 00", $time, {ifa.m1_rvalid, ifa.m0_rvalid});
    end
  end

  always @(posedge clk) begin : mon_b
    exp_t e;
    logic [31:0] grd;
    #3;
    if (qb.size() != 0) begin
      e = qb.pop_front();
      grd = e.mst ? ifb.m1_rdata : ifb.m0_rdata;
      tests_run++;
      if ({ifb.m1_rvalid, ifb.m0_rvalid} !== (e.mst ? 2'b10 : 2'b01) || grd !== e.rdata) begin
        tests_failed++;
        $display("FAIL resp_b t=%0t: rvalid=%b rdata=%h, expected master=%0d rdata=%h",
                 $time, {ifb.m1_rvalid, ifb.m0_rvalid}, grd, e.mst, e.rdata);
      end
    end else if (ifb.m0_rvalid || ifb.m1_rvalid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL resp_b t=%0t: unexpected rvalid=%b, expected 00", $time, {ifb.m1_rvalid, ifb.m0_rvalid});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.m0_req = 0; ifa.m0_we = 0; ifa.m0_addr = 0; ifa.m0_wdata = 0; ifa.m0_wmask = 0;
    ifa.m1_req = 0; ifa.m1_we = 0; ifa.m1_addr = 0; ifa.m1_wdata = 0; ifa.m1_wmask = 0;
  endtask

  task automatic idle_b();
    ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_addr = 0; ifb.m0_wdata = 0; ifb.m0_wmask = 0;
    ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_addr = 0; ifb.m1_wdata = 0; ifb.m1_wmask = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h1000_0000; ifa.m0_wmask = 4'hF;
    ifa.m1_req = 1;
    ifb.m0_req = 1; ifb.m1_req = 1;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if ({ifa.m0_gnt, ifa.m1_gnt, ifa.m0_rvalid, ifa.m1_rvalid, ifa.m0_err, ifa.m1_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags_a: got %b, expected 000000",
               {ifa.m0_gnt, ifa.m1_gnt, ifa.m0_rvalid, ifa.m1_rvalid, ifa.m0_err, ifa.m1_err});
    end
    tests_run++;
    if ({ifa.m0_rdata, ifa.m1_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata_a: got %h %h, expected 0 0", ifa.m0_rdata, ifa.m1_rdata);
    end
    tests_run++;
    if ({ifa.mem_write_enable, ifa.mem_address, ifa.mem_write_mask} !== 37'h0) begin
      tests_failed++;
      $display("FAIL reset_mem_a: we=%b addr=%h mask=%h, expected all 0",
               ifa.mem_write_enable, ifa.mem_address, ifa.mem_write_mask);
    end
    tests_run++;
    if ({ifb.m0_gnt, ifb.m1_gnt, ifb.m0_rvalid, ifb.m1_rvalid} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_flags_b: got %b, expected 0000", {ifb.m0_gnt, ifb.m1_gnt, ifb.m0_rvalid, ifb.m1_rvalid});
    end
    tick();
    reset = 0;
    idle_a();
    idle_b();
  endtask

  task automatic test_write_read();
    ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h1000_0010;
    ifa.m0_wdata = 32'hDEAD_BEEF; ifa.m0_wmask = 4'b0011;
    @(negedge clk);
    tests_run++;
    if ({ifa.m1_gnt, ifa.m0_gnt} !== 2'b01 || ifa.mem_write_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_grant: gnt=%b we=%b, expected 01 1", {ifa.m1_gnt, ifa.m0_gnt}, ifa.mem_write_enable);
    end
    tests_run++;
    if (ifa.mem_address !== 32'h1000_0010 || ifa.mem_write_data !== 32'hDEAD_BEEF || ifa.mem_write_mask !== 4'b0011) begin
      tests_failed++;
      $display("FAIL write_bus: addr=%h data=%h mask=%b, expected 10000010 deadbeef 0011",
               ifa.mem_address, ifa.mem_write_data, ifa.mem_write_mask);
    end
    qa.push_back(mk(1'b0, 1'b0, 32'h0));
    tick();
    idle_a();
    ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_addr = 32'h1000_0010;
    @(negedge clk);
    tests_run++;
    if ({ifa.m1_gnt, ifa.m0_gnt} !== 2'b10 || ifa.mem_write_enable !== 1'b0 || ifa.mem_address !== 32'h1000_0010) begin
      tests_failed++;
      $display("FAIL read_grant: gnt=%b we=%b addr=%h, expected 10 0 10000010",
               {ifa.m1_gnt, ifa.m0_gnt}, ifa.mem_write_enable, ifa.mem_address);
    end
    // Lanes 0/1 of the initial word CAFE0004 were overwritten by BEEF
    qa.push_back(mk(1'b1, 1'b0, 32'hCAFE_BEEF));
    tick();
    idle_a();
    @(negedge clk);
    tests_run++;
    if ({ifa.mem_write_enable, ifa.mem_address, ifa.mem_write_data, ifa.mem_write_mask} !== 69'h0) begin
      tests_failed++;
      $display("FAIL idle_bus: we=%b addr=%h data=%h mask=%h, expected all 0",
               ifa.mem_write_enable, ifa.mem_address, ifa.mem_write_data, ifa.mem_write_mask);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (ifa.m1_rvalid !== 1'b0 || ifa.m1_rdata !== 32'hCAFE_BEEF || ifa.m0_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL rdata_hold: m1_rvalid=%b m1_rdata=%h m0_rdata=%h, expected 0 cafebeef 0",
               ifa.m1_rvalid, ifa.m1_rdata, ifa.m0_rdata);
    end
    tick();
  endtask

  task automatic test_round_robin();
    ifa.m0_req = 1; ifa.m0_addr = 32'h1000_0004;
    ifa.m1_req = 1; ifa.m1_addr = 32'h1000_0008;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if ({ifa.m1_gnt, ifa.m0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("FAIL rr_cycle%0d: gnt=%b, expected %b", i, {ifa.m1_gnt, ifa.m0_gnt},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      qa.push_back((i % 2 == 0) ? mk(1'b0, 1'b0, 32'hCAFE_0001) : mk(1'b1, 1'b0, 32'hCAFE_0002));
      tick();
    end
    idle_a();
  endtask

  task automatic test_lone();
    ifa.m1_req = 1; ifa.m1_addr = 32'h1000_0008;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({ifa.m1_gnt, ifa.m0_gnt} !== 2'b10) begin
        tests_failed++;
        $display("FAIL lone_m1_%0d: gnt=%b, expected 10", i, {ifa.m1_gnt, ifa.m0_gnt});
      end
      qa.push_back(mk(1'b1, 1'b0, 32'hCAFE_0002));
      tick();
    end
    idle_a();
  endtask

  task automatic test_errors();
    ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h0000_0020;
    ifa.m0_wdata = 32'h1234_5678; ifa.m0_wmask = 4'hF;
    @(negedge clk);
    tests_run++;
    if (ifa.m0_gnt !== 1'b1 || ifa.mem_write_enable !== 1'b0 || ifa.mem_address !== 32'h0000_0020) begin
      tests_failed++;
      $display("FAIL rom_write: gnt=%b we=%b addr=%h, expected 1 0 00000020",
               ifa.m0_gnt, ifa.mem_write_enable, ifa.mem_address);
    end
    qa.push_back(mk(1'b0, 1'b1, 32'h0));
    tick();
    idle_a();
    ifa.m1_req = 1; ifa.m1_addr = 32'h2000_0000;
    @(negedge clk);
    tests_run++;
    if (ifa.m1_gnt !== 1'b1 || ifa.mem_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_read: gnt=%b we=%b, expected 1 0", ifa.m1_gnt, ifa.mem_write_enable);
    end
    qa.push_back(mk(1'b1, 1'b1, 32'h0));
    tick();
    idle_a();
    ifa.m0_req = 1; ifa.m0_addr = 32'h0000_0008;
    @(negedge clk);
    tests_run++;
    if (ifa.m0_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL rom_read: gnt=%b, expected 1", ifa.m0_gnt);
    end
    qa.push_back(mk(1'b0, 1'b0, 32'hCAFE_0002));
    tick();
    idle_a();
    tick();
    @(negedge clk);
    tests_run++;
    if (ifa.m0_rvalid !== 1'b0 || ifa.m0_rdata !== 32'hCAFE_0002 || ifa.m1_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL err_hold: m0_rvalid=%b m0_rdata=%h m1_rdata=%h, expected 0 cafe0002 0",
               ifa.m0_rvalid, ifa.m0_rdata, ifa.m1_rdata);
    end
    tick();
  endtask

  task automatic test_reset_pending();
    ifa.m0_req = 1; ifa.m0_addr = 32'h1000_0004;
    @(negedge clk);
    tests_run++;
    if ({ifa.m1_gnt, ifa.m0_gnt} !== 2'b01) begin
      tests_failed++;
      $display("FAIL pre_reset_grant: gnt=%b, expected 01", {ifa.m1_gnt, ifa.m0_gnt});
    end
    tick();
    reset = 1;
    ifa.m1_req = 1; ifa.m1_addr = 32'h1000_0008;
    @(negedge clk);
    tests_run++;
    if (ifa.m0_rvalid !== 1'b0 || {ifa.m1_gnt, ifa.m0_gnt} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_discard: m0_rvalid=%b gnt=%b, expected 0 00", ifa.m0_rvalid, {ifa.m1_gnt, ifa.m0_gnt});
    end
    tick();
    reset = 0;
    @(negedge clk);
    tests_run++;
    if ({ifa.m1_gnt, ifa.m0_gnt} !== 2'b01 || ifa.m0_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_tie: gnt=%b rvalid=%b, expected 01 0", {ifa.m1_gnt, ifa.m0_gnt}, ifa.m0_rvalid);
    end
    qa.push_back(mk(1'b0, 1'b0, 32'hCAFE_0001));
    tick();
    idle_a();
  endtask

  task automatic test_starvation();
    ifb.m0_req = 1; ifb.m0_addr = 32'h1000_0100;
    ifb.m1_req = 1; ifb.m1_addr = 32'h1000_0200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if ({ifb.m1_gnt, ifb.m0_gnt} !== ((i == 4 || i == 9) ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL starve_cycle%0d: gnt=%b, expected %b", i, {ifb.m1_gnt, ifb.m0_gnt},
                 (i == 4 || i == 9) ? 2'b10 : 2'b01);
      end
      qb.push_back((i == 4 || i == 9) ? mk(1'b1, 1'b0, 32'hB000_0200) : mk(1'b0, 1'b0, 32'hB000_0100));
      tick();
    end
    idle_b();
  endtask

  task automatic test_withdraw();
    logic exp_m1;
    ifb.m0_req = 1; ifb.m0_addr = 32'h1000_0100;
    ifb.m1_addr = 32'h1000_0200;
    for (int i = 0; i < 8; i++) begin
      ifb.m1_req = (i != 2);
      exp_m1 = (i == 7);
      @(negedge clk);
      tests_run++;
      if ({ifb.m1_gnt, ifb.m0_gnt} !== (exp_m1 ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("FAIL withdraw_cycle%0d: gnt=%b, expected %b", i, {ifb.m1_gnt, ifb.m0_gnt},
                 exp_m1 ? 2'b10 : 2'b01);
      end
      qb.push_back(exp_m1 ? mk(1'b1, 1'b0, 32'hB000_0200) : mk(1'b0, 1'b0, 32'hB000_0100));
      tick();
    end
    idle_b();
  endtask

  initial begin
    idle_a();
    idle_b();
    test_reset();
    test_write_read();
    test_round_robin();
    test_lone();
    test_errors();
    test_reset_pending();
    test_starvation();
    test_withdraw();
    tick();
    tick();
    tests_run++;
    if (qa.size() != 0 || qb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d/%0d responses outstanding, expected 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
